// File: rtl/panel_loader.sv
// panel_loader
//   Drives an active-low front-panel switch bank on behalf of a command
//   stream: deposit a word (optionally followed by an address increment),
//   press START or press STOP. Each command is a fixed sequence of timed
//   phases. A single 8-bit down-counter times every phase and is reloaded
//   whenever a phase is entered.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   command handshake (accepted when both high at an edge)
//   in_cmd              00 deposit+increment, 01 deposit, 10 start, 11 stop
//   in_data             word to deposit (cmd 00/01)
//   run                 CPU run indicator, asynchronous to clk
//   nsw                 active-low data switches (12'hFFF = released)
//   ndep_sw, nincp_sw   active-low DEPOSIT / INCREMENT strobes
//   nstart_sw, nstop_sw active-low START / STOP strobes
//   err                 one-cycle pulse for a command refused while running
//   count               words deposited since reset (mod 4096)
module panel_loader #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_cmd,
  input  logic [11:0] in_data,
  input  logic        run,
  output logic [11:0] nsw,
  output logic        ndep_sw,
  output logic        nincp_sw,
  output logic        nstart_sw,
  output logic        nstop_sw,
  output logic        err,
  output logic [11:0] count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] DEP   = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] INC   = 3'd4;
  localparam logic [2:0] PRESS = 3'd5;
  localparam logic [2:0] GAP   = 3'd6;

  // The counter is loaded with length-1 so that it reads zero in the last
  // cycle of the phase.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic       is_inc;
  logic       run_p0;
  logic       run_s;
  logic       phase_done;

  assign phase_done = (cnt == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      is_inc    <= 1'b0;
      run_p0    <= 1'b0;
      run_s     <= 1'b0;
      in_ready  <= 1'b1;
      nsw       <= 12'hFFF;
      ndep_sw   <= 1'b1;
      nincp_sw  <= 1'b1;
      nstart_sw <= 1'b1;
      nstop_sw  <= 1'b1;
      err       <= 1'b0;
      count     <= 12'd0;
    end else begin
      // run synchronizer stage boundary
      run_p0 <= run;
      run_s  <= run_p0;
      err    <= 1'b0;
      if (state != IDLE && state != GAP && state != HOLD && state != SETUP
          && state != DEP && state != INC && state != PRESS) begin
        state <= IDLE;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            // STOP is always honoured; everything else is refused while
            // the CPU runs.
            if (in_cmd == 2'b11 || !run_s) begin
              in_ready <= 1'b0;
              if (!in_cmd[1]) begin
                nsw    <= ~in_data;
                is_inc <= ~in_cmd[0];
                state  <= SETUP;
                cnt    <= SETUP_LD;
              end else begin
                state <= PRESS;
                cnt   <= PULSE_LD;
                if (in_cmd[0]) nstop_sw  <= 1'b0;
                else           nstart_sw <= 1'b0;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (phase_done) begin
            state   <= DEP;
            cnt     <= PULSE_LD;
            ndep_sw <= 1'b0;
          end else cnt <= cnt - 8'd1;
        end
        DEP: begin
          if (phase_done) begin
            state   <= HOLD;
            cnt     <= SETUP_LD;
            ndep_sw <= 1'b1;
            count   <= count + 12'd1;
          end else cnt <= cnt - 8'd1;
        end
        HOLD: begin
          if (phase_done) begin
            if (is_inc) begin
              state    <= INC;
              cnt      <= PULSE_LD;
              nincp_sw <= 1'b0;
            end else begin
              state <= GAP;
              cnt   <= SETUP_LD;
              nsw   <= 12'hFFF;
            end
          end else cnt <= cnt - 8'd1;
        end
        INC: begin
          if (phase_done) begin
            state    <= GAP;
            cnt      <= SETUP_LD;
            nincp_sw <= 1'b1;
            nsw      <= 12'hFFF;
          end else cnt <= cnt - 8'd1;
        end
        PRESS: begin
          if (phase_done) begin
            state     <= GAP;
            cnt       <= SETUP_LD;
            nstart_sw <= 1'b1;
            nstop_sw  <= 1'b1;
          end else cnt <= cnt - 8'd1;
        end
        GAP: begin
          if (phase_done) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else cnt <= cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_loader.sv
// Bench for panel_loader: two instances (default timing and 1/1 timing),
// a per-cycle transaction-level model, and directed literal checks.
module tb_panel_loader;

  logic        clk;
  logic        rst;
  logic        v0, v1;
  logic [1:0]  cmd;
  logic [11:0] data;
  logic        run;

  logic        rdy0, dep0, inc0, sta0, sto0, err0;
  logic [11:0] nsw0, cnt0;
  logic        rdy1, dep1, inc1, sta1, sto1, err1;
  logic [11:0] nsw1, cnt1;

  int checks = 0;
  int errors = 0;

  panel_loader dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_cmd(cmd),
    .in_data(data), .run(run), .nsw(nsw0), .ndep_sw(dep0), .nincp_sw(inc0),
    .nstart_sw(sta0), .nstop_sw(sto0), .err(err0), .count(cnt0)
  );

  panel_loader #(.SETUP_CYC(1), .PULSE_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_cmd(cmd),
    .in_data(data), .run(run), .nsw(nsw1), .ndep_sw(dep1), .nincp_sw(inc1),
    .nstart_sw(sta1), .nstop_sw(sto1), .err(err1), .count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] nsw;
    logic        dep;
    logic        inc;
    logic        sta;
    logic        sto;
    logic        err;
    logic        rdy;
    logic [11:0] cnt;
  } o_t;

  // Transaction-level model: each accepted command is a timeline of phase
  // lengths; expected outputs come from the position k inside it.
  int          ms[2] = '{2, 1};
  int          mp[2] = '{4, 1};
  bit          busy[2];
  int          kk[2];
  logic [1:0]  mcmd[2];
  logic [11:0] mdata[2];
  logic [11:0] mcount[2];
  bit          errp[2];
  bit          r1[2], r2[2];
  int          acc[2];

  function automatic int cmd_len(int i);
    if (mcmd[i] == 2'b00) return 3 * ms[i] + 2 * mp[i];
    if (mcmd[i] == 2'b01) return 3 * ms[i] + mp[i];
    return mp[i] + ms[i];
  endfunction

  function automatic o_t model_out(int i);
    o_t o;
    int s, p, k, len;
    o.nsw = 12'hFFF; o.dep = 1'b1; o.inc = 1'b1; o.sta = 1'b1; o.sto = 1'b1;
    o.err = errp[i]; o.rdy = !busy[i]; o.cnt = mcount[i];
    if (busy[i]) begin
      s = ms[i]; p = mp[i]; k = kk[i]; len = cmd_len(i);
      if (!mcmd[i][1]) begin
        if (k <= s + p) o.cnt = mcount[i] - 12'd1;
        if (k <= len - s) o.nsw = ~mdata[i];
        if (k > s && k <= s + p) o.dep = 1'b0;
        if (mcmd[i] == 2'b00 && k > 2 * s + p && k <= 2 * s + 2 * p) o.inc = 1'b0;
      end else if (k <= p) begin
        if (mcmd[i][0]) o.sto = 1'b0;
        else            o.sta = 1'b0;
      end
    end
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        busy[i] = 0; kk[i] = 0; mcount[i] = 12'd0; errp[i] = 0;
        r1[i] = 0; r2[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit rdy_b, rs, vi;
        vi = (i == 0) ? v0 : v1;
        rdy_b = !busy[i];
        errp[i] = 0;
        if (busy[i]) begin
          kk[i]++;
          if (kk[i] > cmd_len(i)) busy[i] = 0;
        end
        rs = r2[i]; r2[i] = r1[i]; r1[i] = run;
        if (rdy_b && vi) begin
          if (cmd == 2'b11 || !rs) begin
            busy[i] = 1; kk[i] = 1; mcmd[i] = cmd; mdata[i] = data; acc[i]++;
            if (!cmd[1]) mcount[i] = mcount[i] + 12'd1;
          end else errp[i] = 1;
        end
      end
    end
  end

  // Per-cycle comparison plus the strobe-exclusivity and nsw-stability rules.
  logic [11:0] prev_nsw[2];
  bit          prev_lo[2];

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        o_t e, a;
        int lows;
        if (i == 0) a = '{nsw0, dep0, inc0, sta0, sto0, err0, rdy0, cnt0};
        else        a = '{nsw1, dep1, inc1, sta1, sto1, err1, rdy1, cnt1};
        e = model_out(i);
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL model dut%0d t=%0t: got nsw=%h dep=%b inc=%b sta=%b sto=%b err=%b rdy=%b cnt=%0d, want nsw=%h dep=%b inc=%b sta=%b sto=%b err=%b rdy=%b cnt=%0d",
                   i, $time, a.nsw, a.dep, a.inc, a.sta, a.sto, a.err, a.rdy, a.cnt,
                   e.nsw, e.dep, e.inc, e.sta, e.sto, e.err, e.rdy, e.cnt);
        end
        lows = 32'(!a.dep) + 32'(!a.inc) + 32'(!a.sta) + 32'(!a.sto);
        checks++;
        if (lows > 1) begin
          errors++;
          $display("FAIL strobes dut%0d t=%0t: %0d low, want at most 1", i, $time, lows);
        end
        if ((!a.dep || !a.inc) && prev_lo[i]) begin
          checks++;
          if (a.nsw !== prev_nsw[i]) begin
            errors++;
            $display("FAIL nsw_stable dut%0d t=%0t: got %h want %h", i, $time, a.nsw, prev_nsw[i]);
          end
        end
        prev_lo[i]  = !a.dep || !a.inc;
        prev_nsw[i] = a.nsw;
      end
    end else begin
      prev_lo[0] = 0; prev_lo[1] = 0;
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d: got %0h want %0h", name, k, act, exp);
    end
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (((i == 0) ? rdy0 : rdy1) !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL ready_timeout dut%0d: got 0 want 1", i);
    end
  endtask

  // Drives one command for exactly one edge; returns just after that edge.
  task automatic send(input int i, input logic [1:0] c, input logic [11:0] d);
    cmd = c; data = d;
    if (i == 0) v0 = 1'b1; else v1 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; run = 1'b0; cmd = 2'b00; data = 12'h000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 0, 32'(rdy0), 32'd1);
    chk("count_after_rst", 0, 32'(cnt0), 32'd0);
    chk("nsw_after_rst",   0, 32'(nsw0), 32'hFFF);
    @(posedge clk); #1;

    // Deposit+increment, default timing. Cycle k follows accepting edge k-1;
    // in_ready comes back on edge 14, i.e. from cycle 15.
    send(0, 2'b00, 12'h5A3);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("d00_nsw",   k, 32'(nsw0), (k <= 12) ? 32'hA5C : 32'hFFF);
      chk("d00_ndep",  k, 32'(dep0), (k >= 3 && k <= 6) ? 32'd0 : 32'd1);
      chk("d00_nincp", k, 32'(inc0), (k >= 9 && k <= 12) ? 32'd0 : 32'd1);
      chk("d00_ready", k, 32'(rdy0), (k >= 15) ? 32'd1 : 32'd0);
    end
    chk("d00_count", 0, 32'(cnt0), 32'd1);
    @(posedge clk); #1;

    // Deposit only.
    wait_ready(0);
    send(0, 2'b01, 12'hFFF);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k >= 3 && k <= 6) chk("d01_nsw", k, 32'(nsw0), 32'h000);
      chk("d01_ndep",  k, 32'(dep0), (k >= 3 && k <= 6) ? 32'd0 : 32'd1);
      chk("d01_nincp", k, 32'(inc0), 32'd1);
      chk("d01_ready", k, 32'(rdy0), (k >= 11) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;

    // Start refused while running, stop honoured.
    run = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    wait_ready(0);
    send(0, 2'b10, 12'h000);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("start_err",    k, 32'(err0), (k == 1) ? 32'd1 : 32'd0);
      chk("start_nstart", k, 32'(sta0), 32'd1);
      chk("start_ready",  k, 32'(rdy0), 32'd1);
    end
    chk("start_count", 0, 32'(cnt0), 32'd2);
    @(posedge clk); #1;
    send(0, 2'b11, 12'h000);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("stop_nstop", k, 32'(sto0), (k <= 4) ? 32'd0 : 32'd1);
      chk("stop_ready", k, 32'(rdy0), (k >= 7) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    run = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // Reset in the middle of DEP.
    wait_ready(0);
    send(0, 2'b00, 12'h123);
    repeat (4) @(negedge clk);
    chk("rst_in_dep", 4, 32'(dep0), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_ndep",  0, 32'(dep0), 32'd1);
    chk("rst_nsw",   0, 32'(nsw0), 32'hFFF);
    chk("rst_count", 0, 32'(cnt0), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 0, 32'(rdy0), 32'd1);
    @(posedge clk); #1;

    // Minimum timing on the second instance.
    wait_ready(1);
    send(1, 2'b00, 12'h0F0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("fast_nsw",   k, 32'(nsw1), (k <= 4) ? 32'hF0F : 32'hFFF);
      chk("fast_ndep",  k, 32'(dep1), (k == 2) ? 32'd0 : 32'd1);
      chk("fast_nincp", k, 32'(inc1), (k == 4) ? 32'd0 : 32'd1);
      chk("fast_ready", k, 32'(rdy1), (k >= 6) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;

    // 4097 back-to-back deposits on both instances: counter wraps.
    acc[0] = 0; acc[1] = 0;
    cmd = 2'b00; data = 12'h3C5;
    v0 = 1'b1; v1 = 1'b1;
    guard = 0;
    while ((v0 || v1) && guard < 4097 * 15 + 400) begin
      @(posedge clk); #1;
      guard++;
      if (acc[0] >= 4097) v0 = 1'b0;
      if (acc[1] >= 4097) v1 = 1'b0;
    end
    chk("b2b_finished", 0, 32'(v0 || v1), 32'd0);
    v0 = 1'b0; v1 = 1'b0;
    wait_ready(0);
    wait_ready(1);
    @(negedge clk);
    chk("b2b_count0", 0, 32'(cnt0), 32'd1);
    chk("b2b_count1", 0, 32'(cnt1), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
